// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit scheduler and
// the UART receiver.
//   tx_state_t      - transmit serialiser states
//   LINE_IDLE       - level of an idle serial line (mark)
//   DEFAULT_DATA_W  - default number of data bits per frame
package uart_pkg;

    localparam logic LINE_IDLE      = 1'b1;
    localparam int   DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin selector for NUM_REQ requesters.
// The one-hot select is combinational. It picks the first set req bit at or
// after the priority pointer and wraps modulo NUM_REQ. The pointer is
// registered and moves to one past the winner only when accept is strobed.
// Ports:
//   clk_in   in   system clock
//   rst_n    in   synchronous active-low reset (pointer -> 0)
//   req      in   NUM_REQ request vector
//   accept   in   winner is taken this cycle; advance the pointer
//   gnt      out  NUM_REQ one-hot select (all zero when no request)
//   gnt_idx  out  binary index of the selected requester
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   pos;
    logic             found;

    // Scan from ptr upward. pos carries one extra bit so the wrap works for
    // non-power-of-2 NUM_REQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_REQ))
                pos = pos - (IDX_W+1)'(NUM_REQ);
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[pos[IDX_W-1:0]]   = 1'b1;
                gnt_idx               = pos[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept)
            ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART TX line between NUM_REQ byte producers.
// Requesters are granted round-robin. The granted byte is sent as a frame of
// one start bit, DATA_W data bits (LSB first) and STOP_BITS stop bits. Each
// bit lasts one baud_tick period.
// Ports:
//   clk_in     in   system clock
//   rst_n      in   synchronous active-low reset
//   baud_tick  in   one-cycle pulse per bit period
//   req_valid  in   per-requester byte valid
//   req_data   in   requester i's byte at [i*DATA_W +: DATA_W]
//   req_ready  out  one-cycle one-hot accept strobe
//   tx_out     out  serial line, idle high
//   busy       out  high from the accept cycle through the last stop bit
//   grant_id   out  index of the current/last granted requester
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int STOP_BITS = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic                        baud_tick,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_out,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(DATA_W+1);
    localparam int SCNT_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SCNT_W-1:0] stop_cnt;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0]  sel_idx;
    logic              accept;

    assign accept = (state == IDLE) && (|req_valid);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .req     (req_valid),
        .accept  (accept),
        .gnt     (sel_onehot),
        .gnt_idx (sel_idx)
    );

    // Ticks only advance the frame once the FSM has left IDLE. A tick that
    // lands on the accept cycle is therefore dropped, and the start bit
    // begins on the following tick.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_out    <= LINE_IDLE;
            req_ready <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= sel_onehot;
                        shreg     <= req_data[sel_idx*DATA_W +: DATA_W];
                        grant_id  <= sel_idx;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (baud_tick) begin
                        tx_out <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= CNT_W'(1);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    // bit_cnt counts data bits already driven. The MSB is
                    // held one full period before the stop bit starts.
                    if (baud_tick) begin
                        if (bit_cnt == CNT_W'(DATA_W)) begin
                            tx_out   <= LINE_IDLE;
                            stop_cnt <= '0;
                            state    <= STOP;
                        end else begin
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == SCNT_W'(STOP_BITS-1)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + SCNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        baud_tick;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  ready1, ready2;
    logic        tx1, tx2, busy1, busy2;
    logic [1:0]  gid1, gid2;

    always #5 clk_in = ~clk_in;

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(1)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .baud_tick(baud_tick),
        .req_valid(req_valid), .req_data(req_data), .req_ready(ready1),
        .tx_out(tx1), .busy(busy1), .grant_id(gid1)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(2)) dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .baud_tick(baud_tick),
        .req_valid(req_valid), .req_data(req_data), .req_ready(ready2),
        .tx_out(tx2), .busy(busy2), .grant_id(gid2)
    );

    // Transaction-level reference: a frame is a fixed bit list indexed by the
    // number of baud ticks seen since the accept.
    typedef struct {
        logic       busy;
        int         ticks;
        int         ptr;
        int         grant;
        logic [3:0] ready;
        logic       line;
        logic [7:0] data;
    } mdl_t;

    mdl_t m1, m2;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   tick_mode = 0;   // 0: every 4 cycles, 1: tied high, 2: random
    logic [15:0] seq1, seq2;
    int   ns1, ns2;

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        return 1'b1;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int sb, input logic rn,
                                   input logic tk, input logic [3:0] v,
                                   input logic [31:0] d);
        mdl_t n;
        logic found;
        n = m;
        n.ready = 4'b0000;
        found = 1'b0;
        if (!rn) begin
            n.busy = 1'b0; n.ticks = 0; n.ptr = 0; n.grant = 0; n.line = 1'b1;
        end else if (!m.busy) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m.ptr + k) % 4;
                if (!found && v[j]) begin
                    found = 1'b1;
                    n.ready[j] = 1'b1;
                    n.grant = j;
                    n.ptr = (j + 1) % 4;
                    n.busy = 1'b1;
                    n.ticks = 0;
                    n.data = d[j*8 +: 8];
                end
            end
        end else if (tk) begin
            n.ticks = m.ticks + 1;
            // Frame has 9+sb bit periods; the tick after the last one ends it.
            if (n.ticks == 10 + sb) begin
                n.busy = 1'b0;
                n.line = 1'b1;
            end else begin
                n.line = frame_bit(m.data, n.ticks - 1);
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic pb1, pb2, tk;
        pb1 = m1.busy; pb2 = m2.busy; tk = baud_tick;
        @(posedge clk_in);
        m1 = mstep(m1, 1, rst_n, baud_tick, req_valid, req_data);
        m2 = mstep(m2, 2, rst_n, baud_tick, req_valid, req_data);
        @(negedge clk_in);
        chk("tx1", tx1, m1.line);
        chk("busy1", busy1, m1.busy);
        chk("ready1", ready1, m1.ready);
        chk("gid1", gid1, m1.grant);
        chk("tx2", tx2, m2.line);
        chk("busy2", busy2, m2.busy);
        chk("ready2", ready2, m2.ready);
        chk("gid2", gid2, m2.grant);
        if (pb1 && tk && ns1 < 16) begin seq1[ns1] = tx1; ns1++; end
        if (pb2 && tk && ns2 < 16) begin seq2[ns2] = tx2; ns2++; end
        cyc++;
        case (tick_mode)
            0:       baud_tick = (cyc % 4 == 0);
            1:       baud_tick = 1'b1;
            default: baud_tick = ($urandom_range(0, 2) == 0);
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int i, acc, idle, grants;
        m1 = '{busy:1'b0, ticks:0, ptr:0, grant:0, ready:4'b0, line:1'b1, data:8'h0};
        m2 = m1;
        seq1 = '0; seq2 = '0; ns1 = 0; ns2 = 0;
        rst_n = 1'b0; baud_tick = 1'b0; req_valid = 4'hF; req_data = $urandom;

        // Reset held with every requester valid.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_tx", tx1, 1);
            chk("rst_ready", ready1, 0);
            chk("rst_busy", busy1, 0);
            chk("rst_gid", gid1, 0);
        end
        rst_n = 1'b1;
        req_valid = 4'h0;

        // Single byte from requester 2.
        req_valid = 4'b0100; req_data = 32'h00A5_0000;
        step();
        chk("t2_ready", ready1, 4'b0100);
        chk("t2_gid", gid1, 2);
        req_valid = 4'h0; req_data = $urandom;
        ns1 = 0;
        for (i = 0; i < 100 && m1.busy; i++) step();
        chk("t2_timeout", (i >= 100), 0);
        chk("t2_bits", seq1[9:0], 10'h34A);
        chk("t2_nticks", ns1, 11);
        chk("t2_busy", busy1, 0);

        // Fairness: every requester valid, each with its own byte.
        do_reset();
        req_valid = 4'hF; req_data = 32'h0302_0100;
        grants = 0;
        for (i = 0; i < 400 && grants < 5; i++) begin
            step();
            if (ready1 != 4'b0) begin
                chk("t3_order", gid1, grants % 4);
                grants++;
            end
        end
        chk("t3_timeout", (i >= 400), 0);
        req_valid = 4'h0;

        // Accept on the same cycle as a baud tick.
        for (i = 0; i < 200 && (m1.busy || m2.busy); i++) step();
        chk("t4_idle_to", (i >= 200), 0);
        for (i = 0; i < 8 && !baud_tick; i++) step();
        req_valid = 4'b0010; req_data = $urandom;
        step();
        chk("t4_ready", ready1, 4'b0010);
        req_valid = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold", tx1, 1);
        end
        step();
        chk("t4_start", tx1, 0);

        // Reset during data bit 3 of 8'hFF, then check the pointer restarted.
        do_reset();
        req_valid = 4'b0100; req_data = 32'h00FF_0000;
        step();
        req_valid = 4'h0;
        for (i = 0; i < 100 && m1.ticks < 5; i++) step();
        chk("t5_timeout", (i >= 100), 0);
        rst_n = 1'b0;
        step();
        chk("t5_tx", tx1, 1);
        chk("t5_busy", busy1, 0);
        rst_n = 1'b1;
        req_valid = 4'hF; req_data = $urandom;
        step();
        chk("t5_ready", ready1, 4'b0001);
        chk("t5_gid", gid1, 0);
        req_valid = 4'h0;

        // STOP_BITS=2 with baud_tick tied high, back-to-back from one requester.
        tick_mode = 1; baud_tick = 1'b1;
        do_reset();
        req_valid = 4'b0001; req_data = 32'h0000_0080;
        ns2 = 0; acc = 0; idle = 0;
        for (i = 0; i < 60 && acc < 2; i++) begin
            step();
            if (ready2 != 4'b0) acc++;
            else if (acc == 1 && !busy2) idle++;
        end
        chk("t6_timeout", (i >= 60), 0);
        chk("t6_bits", seq2[10:0], 11'h700);
        chk("t6_gap", idle, 1);
        req_valid = 4'h0;

        // Random traffic, random tick pattern, occasional reset.
        tick_mode = 2;
        for (int k = 0; k < 3000; k++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 9) == 0) req_valid = 4'hF;
            req_data  = $urandom;
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;

        // Random traffic with baud_tick held high.
        tick_mode = 1;
        for (int k = 0; k < 800; k++) begin
            req_valid = 4'($urandom);
            req_data  = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
